// File: rtl/swap_decode_reg_if.sv
// Signal bundle for swap_decode_reg: swap-mux paths, decoder, and enabled register.
// The bench drives through the master modport and the design uses the slave modport.
interface swap_decode_reg_if #(
  parameter int CMUX_WIDTH = 32,
  parameter int REG_WIDTH  = 2
);
  logic [CMUX_WIDTH-1:0] cmux_d0;
  logic [CMUX_WIDTH-1:0] cmux_d1;
  logic                  cmux_s;
  logic [CMUX_WIDTH-1:0] cmux_y0;
  logic [CMUX_WIDTH-1:0] cmux_y1;
  logic [1:0]            dec_a;
  logic [3:0]            dec_y;
  logic                  reg_en;
  logic [REG_WIDTH-1:0]  reg_d;
  logic [REG_WIDTH-1:0]  reg_q;

  modport master (
    output cmux_d0, cmux_d1, cmux_s, dec_a, reg_en, reg_d,
    input  cmux_y0, cmux_y1, dec_y, reg_q
  );

  modport slave (
    input  cmux_d0, cmux_d1, cmux_s, dec_a, reg_en, reg_d,
    output cmux_y0, cmux_y1, dec_y, reg_q
  );
endinterface

// File: rtl/swap_decode_reg.sv
// Memory-subsystem primitives: crossover swap mux, 2-to-4 one-hot decoder and an
// enabled register with async reset. The three functions share only ph1/reset.
module swap_decode_reg #(
  parameter int CMUX_WIDTH = 32,
  parameter int REG_WIDTH  = 2
) (
  input  logic              ph1,
  input  logic              reset,
  swap_decode_reg_if.slave  bus
);

  logic [CMUX_WIDTH-1:0] y0;
  logic [CMUX_WIDTH-1:0] y1;
  logic [3:0]            dec;
  logic [REG_WIDTH-1:0]  data_d;
  logic [REG_WIDTH-1:0]  data_q;

  // An unknown select poisons both outputs rather than merging the two sources.
  always_comb begin
    y0 = '0;
    y1 = '0;
    case (bus.cmux_s)
      1'b0: begin
        y0 = bus.cmux_d0;
        y1 = bus.cmux_d1;
      end
      1'b1: begin
        y0 = bus.cmux_d1;
        y1 = bus.cmux_d0;
      end
      default: begin
        y0 = 'x;
        y1 = 'x;
      end
    endcase
  end

  always_comb begin
    dec = 4'b0000;
    case (bus.dec_a)
      2'd0:    dec = 4'b0001;
      2'd1:    dec = 4'b0010;
      2'd2:    dec = 4'b0100;
      2'd3:    dec = 4'b1000;
      default: dec = 4'bxxxx;
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (bus.reg_en) begin
      data_d = bus.reg_d;
    end
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bus.cmux_y0 = y0;
  assign bus.cmux_y1 = y1;
  assign bus.dec_y   = dec;
  assign bus.reg_q   = data_q;

endmodule

// File: tb/tb_swap_decode_reg.sv
// Self-checking bench for swap_decode_reg: expected values are queued when stimulus
// is applied and popped when the corresponding output is sampled.
module tb_swap_decode_reg;

  localparam int CW = 32;
  localparam int RW = 2;

  logic ph1 = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [CW-1:0] exp_y0_q [$];
  logic [CW-1:0] exp_y1_q [$];
  logic [3:0]    exp_dec_q [$];
  logic [RW-1:0] exp_reg_q [$];

  swap_decode_reg_if #(.CMUX_WIDTH(CW), .REG_WIDTH(RW)) bus ();

  swap_decode_reg #(.CMUX_WIDTH(CW), .REG_WIDTH(RW)) dut (
    .ph1   (ph1),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ph1 = ~ph1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: timeout actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    logic [RW-1:0] e;
    reset       = 1'b1;
    bus.cmux_d0 = '0;
    bus.cmux_d1 = '0;
    bus.cmux_s  = 1'b0;
    bus.dec_a   = 2'd0;
    bus.reg_en  = 1'b1;
    bus.reg_d   = 2'b11;
    exp_reg_q.push_back(2'b00);
    @(negedge ph1);
    @(negedge ph1);
    e = exp_reg_q.pop_front();
    checks++;
    if (bus.reg_q !== e) begin
      errors++;
      $display("[TB] FAIL reset_value: actual=%b required=%b", bus.reg_q, e);
    end
  endtask

  task automatic test_swap();
    logic [CW-1:0] e0, e1;
    bus.cmux_d0 = 32'h0000_00AA;
    bus.cmux_d1 = 32'h0000_0055;
    bus.cmux_s  = 1'b0;
    exp_y0_q.push_back(32'h0000_00AA);
    exp_y1_q.push_back(32'h0000_0055);
    #1;
    e0 = exp_y0_q.pop_front();
    e1 = exp_y1_q.pop_front();
    checks += 2;
    if (bus.cmux_y0 !== e0) begin
      errors++;
      $display("[TB] FAIL swap_straight_y0: actual=%h required=%h", bus.cmux_y0, e0);
    end
    if (bus.cmux_y1 !== e1) begin
      errors++;
      $display("[TB] FAIL swap_straight_y1: actual=%h required=%h", bus.cmux_y1, e1);
    end
    bus.cmux_s = 1'b1;
    exp_y0_q.push_back(32'h0000_0055);
    exp_y1_q.push_back(32'h0000_00AA);
    #1;
    e0 = exp_y0_q.pop_front();
    e1 = exp_y1_q.pop_front();
    checks += 2;
    if (bus.cmux_y0 !== e0) begin
      errors++;
      $display("[TB] FAIL swap_crossed_y0: actual=%h required=%h", bus.cmux_y0, e0);
    end
    if (bus.cmux_y1 !== e1) begin
      errors++;
      $display("[TB] FAIL swap_crossed_y1: actual=%h required=%h", bus.cmux_y1, e1);
    end
  endtask

  task automatic test_swap_full();
    logic [CW-1:0] e0, e1;
    bus.cmux_d0 = 32'hFFFF_FFFF;
    bus.cmux_d1 = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge ph1);
      bus.cmux_s = i[0];
      exp_y0_q.push_back(i[0] ? 32'h0000_0000 : 32'hFFFF_FFFF);
      exp_y1_q.push_back(i[0] ? 32'hFFFF_FFFF : 32'h0000_0000);
      #1;
      e0 = exp_y0_q.pop_front();
      e1 = exp_y1_q.pop_front();
      checks += 2;
      if (bus.cmux_y0 !== e0) begin
        errors++;
        $display("[TB] FAIL swap_full_y0[%0d]: actual=%h required=%h", i, bus.cmux_y0, e0);
      end
      if (bus.cmux_y1 !== e1) begin
        errors++;
        $display("[TB] FAIL swap_full_y1[%0d]: actual=%h required=%h", i, bus.cmux_y1, e1);
      end
    end
  endtask

  task automatic test_decoder();
    logic [3:0] tbl [4];
    logic [3:0] e;
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      bus.dec_a = 2'(i);
      exp_dec_q.push_back(tbl[i]);
      #1;
      e = exp_dec_q.pop_front();
      checks++;
      if (bus.dec_y !== e) begin
        errors++;
        $display("[TB] FAIL decode[%0d]: actual=%b required=%b", i, bus.dec_y, e);
      end
    end
  endtask

  task automatic test_reg_load_hold();
    logic [RW-1:0] e;
    @(negedge ph1);
    reset      = 1'b0;
    bus.reg_en = 1'b1;
    bus.reg_d  = 2'b10;
    exp_reg_q.push_back(2'b10);
    @(negedge ph1);
    e = exp_reg_q.pop_front();
    checks++;
    if (bus.reg_q !== e) begin
      errors++;
      $display("[TB] FAIL reg_load: actual=%b required=%b", bus.reg_q, e);
    end
    bus.reg_en = 1'b0;
    bus.reg_d  = 2'b01;
    for (int i = 0; i < 3; i++) begin
      exp_reg_q.push_back(2'b10);
      @(negedge ph1);
      e = exp_reg_q.pop_front();
      checks++;
      if (bus.reg_q !== e) begin
        errors++;
        $display("[TB] FAIL reg_hold[%0d]: actual=%b required=%b", i, bus.reg_q, e);
      end
    end
    bus.reg_en = 1'b1;
    exp_reg_q.push_back(2'b01);
    @(negedge ph1);
    e = exp_reg_q.pop_front();
    checks++;
    if (bus.reg_q !== e) begin
      errors++;
      $display("[TB] FAIL reg_reload: actual=%b required=%b", bus.reg_q, e);
    end
  endtask

  task automatic test_async_reset();
    logic [RW-1:0] e;
    bus.reg_en = 1'b1;
    bus.reg_d  = 2'b11;
    exp_reg_q.push_back(2'b11);
    @(negedge ph1);
    e = exp_reg_q.pop_front();
    checks++;
    if (bus.reg_q !== e) begin
      errors++;
      $display("[TB] FAIL reg_load_11: actual=%b required=%b", bus.reg_q, e);
    end
    #1;
    reset = 1'b1;
    exp_reg_q.push_back(2'b00);
    #1;
    e = exp_reg_q.pop_front();
    checks++;
    if (bus.reg_q !== e) begin
      errors++;
      $display("[TB] FAIL async_clear: actual=%b required=%b", bus.reg_q, e);
    end
    for (int i = 0; i < 2; i++) begin
      exp_reg_q.push_back(2'b00);
      @(negedge ph1);
      e = exp_reg_q.pop_front();
      checks++;
      if (bus.reg_q !== e) begin
        errors++;
        $display("[TB] FAIL reset_hold[%0d]: actual=%b required=%b", i, bus.reg_q, e);
      end
    end
  endtask

  task automatic test_reset_release();
    logic [RW-1:0] e;
    reset      = 1'b0;
    bus.reg_en = 1'b1;
    bus.reg_d  = 2'b01;
    exp_reg_q.push_back(2'b00);
    #1;
    e = exp_reg_q.pop_front();
    checks++;
    if (bus.reg_q !== e) begin
      errors++;
      $display("[TB] FAIL release_no_load: actual=%b required=%b", bus.reg_q, e);
    end
    exp_reg_q.push_back(2'b01);
    @(negedge ph1);
    e = exp_reg_q.pop_front();
    checks++;
    if (bus.reg_q !== e) begin
      errors++;
      $display("[TB] FAIL release_load: actual=%b required=%b", bus.reg_q, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] e;
    logic [RW-1:0] seq [3];
    // Enable pulses between edges must not load; only the level at the edge counts.
    bus.reg_d  = 2'b10;
    bus.reg_en = 1'b0;
    #2 bus.reg_en = 1'b1;
    #2 bus.reg_en = 1'b0;
    exp_reg_q.push_back(2'b01);
    @(negedge ph1);
    e = exp_reg_q.pop_front();
    checks++;
    if (bus.reg_q !== e) begin
      errors++;
      $display("[TB] FAIL en_glitch_ignored: actual=%b required=%b", bus.reg_q, e);
    end
    #1 bus.reg_en = 1'b0;
    #2 bus.reg_en = 1'b1;
    exp_reg_q.push_back(2'b10);
    @(negedge ph1);
    e = exp_reg_q.pop_front();
    checks++;
    if (bus.reg_q !== e) begin
      errors++;
      $display("[TB] FAIL en_at_edge: actual=%b required=%b", bus.reg_q, e);
    end
    seq = '{2'b00, 2'b11, 2'b01};
    for (int i = 0; i < 3; i++) begin
      bus.reg_d = seq[i];
      exp_reg_q.push_back(seq[i]);
      @(negedge ph1);
      e = exp_reg_q.pop_front();
      checks++;
      if (bus.reg_q !== e) begin
        errors++;
        $display("[TB] FAIL b2b_load[%0d]: actual=%b required=%b", i, bus.reg_q, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_swap();
    test_swap_full();
    test_decoder();
    test_reg_load_hold();
    test_async_reset();
    test_reset_release();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
